rxn_stimulus: RTL and testbench



---
 rtl/rxn_pkg.sv | 18 +
 rtl/lfsr16.sv | 24 ++
 rtl/rxn_stimulus.sv | 159 +++++++++++++++
 tb/tb_rxn_stimulus.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rxn_pkg.sv
// rtl/rxn_pkg.sv - shared types and LFSR constants for the reaction-time stimulus block
package rxn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    PROMPT,
    WAIT_DONE,
    CAPTURE,
    FAULT
  } rxn_state_e;

  typedef logic [31:0] rxn_time_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit right-shifting Galois LFSR
module lfsr16
  import rxn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/rxn_stimulus.sv
// rtl/rxn_stimulus.sv - reaction-time game sequencer: random delay, prompt, timer start/stop, capture
// Optional false-start detection enabled by defining RXN_FALSE_START_EN.
module rxn_stimulus
  import rxn_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 50_000_000,
  parameter int          RAND_BITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        btn,
  input  logic        rxn_done,
  input  logic [31:0] rxn_time,
  output logic        start,
  output logic        stop,
  output logic        led,
  output logic        busy,
  output logic        false_start,
  output logic        result_valid,
  output logic [31:0] result
);

  // Only 16 LFSR bits exist; wider RAND_BITS settings saturate there.
  localparam int          RB_EFF    = (RAND_BITS > 16) ? 16 : RAND_BITS;
  localparam logic [15:0] RAND_MASK = 16'((32'd1 << RB_EFF) - 32'd1);

  if (RAND_BITS < 1 || RAND_BITS > 26) begin : g_bad_rand_bits
    $error("rxn_stimulus: RAND_BITS must be in 1..26");
  end
  if (64'(MIN_DELAY) + 64'(RAND_MASK) > 64'hFFFF_FFFF) begin : g_bad_delay
    $error("rxn_stimulus: MIN_DELAY plus random addend overflows 32 bits");
  end

  rxn_state_e  state_q, state_d;
  rxn_time_t   cnt_q, cnt_d;
  rxn_time_t   result_q, result_d;
  logic        arm_q, btn_q;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        valid_q, valid_d;
  logic [15:0] lfsr;
  logic        arm_edge, btn_edge;
  rxn_time_t   reload;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign arm_edge = arm & ~arm_q;
  assign btn_edge = btn & ~btn_q;
  assign reload   = rxn_time_t'(MIN_DELAY) + {16'd0, lfsr & RAND_MASK};

`ifdef RXN_FALSE_START_EN
  logic fs_q, fs_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    valid_d  = 1'b0;
`ifdef RXN_FALSE_START_EN
    fs_d     = fs_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm_edge) begin
          cnt_d   = reload;
          state_d = DELAY;
        end
      end
      DELAY: begin
`ifdef RXN_FALSE_START_EN
        // A premature press wins even on the cycle the delay expires.
        if (btn_edge) begin
          fs_d    = 1'b1;
          state_d = FAULT;
        end else
`endif
        if (cnt_q == '0) begin
          start_d = 1'b1;
          state_d = PROMPT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PROMPT: begin
        if (btn_edge) begin
          stop_d  = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rxn_done) state_d = CAPTURE;
      end
      CAPTURE: begin
        result_d = rxn_time;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
`ifdef RXN_FALSE_START_EN
      FAULT: begin
        if (arm_edge) begin
          fs_d    = 1'b0;
          cnt_d   = reload;
          state_d = DELAY;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      arm_q    <= 1'b0;
      btn_q    <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      arm_q    <= arm;
      btn_q    <= btn;
      start_q  <= start_d;
      stop_q   <= stop_d;
      valid_q  <= valid_d;
    end
  end

`ifdef RXN_FALSE_START_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fs_q <= 1'b0;
    else        fs_q <= fs_d;
  end
  assign false_start = fs_q;
`else
  assign false_start = 1'b0;
`endif

  // Pulses are registered so start rises together with the prompt LED.
  assign start        = start_q;
  assign stop         = stop_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign led          = (state_q == PROMPT);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rxn_stimulus.sv
// tb/tb_rxn_stimulus.sv - randomized self-checking bench for rxn_stimulus against a behavioural model
module tb_rxn_stimulus;

  localparam int MIN_D = 4;
  localparam int RB    = 3;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        arm      = 1'b0;
  logic        btn      = 1'b0;
  logic        rxn_done = 1'b0;
  logic [31:0] rxn_time = '0;
  logic        start, stop, led, busy, false_start, result_valid;
  logic [31:0] result;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_rv = 0, n_overlap = 0, cyc = 0;

  rxn_stimulus #(.MIN_DELAY(MIN_D), .RAND_BITS(RB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .btn          (btn),
    .rxn_done     (rxn_done),
    .rxn_time     (rxn_time),
    .start        (start),
    .stop         (stop),
    .led          (led),
    .busy         (busy),
    .false_start  (false_start),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // LFSR value n clock edges after reset release, from the shift/tap rule.
  function automatic logic [15:0] lfsr_nth(input int n);
    logic [15:0] x;
    x = 16'hACE1;
    for (int k = 0; k < n; k++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    return x;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rst_n) cyc++;
    if (start) n_start++;
    if (stop) n_stop++;
    if (result_valid) n_rv++;
    if (start && stop) n_overlap++;
  endtask

  // Arm and wait for the prompt; start is expected MIN_D + lfsr[RB-1:0] + 1 cycles after the arm edge.
  task automatic arm_to_prompt(input bit hold_btn, input bit glitch);
    logic [15:0] lf;
    int lat, got;
    lf  = lfsr_nth(cyc);
    lat = MIN_D + int'(lf[RB-1:0]) + 1;
    got = 0;
    arm = 1'b1;
    for (int i = 1; i <= 64 && got == 0; i++) begin
      tick();
      arm = glitch && (i == 3);
      if (hold_btn && i == 2) btn = 1'b1;
      if (start) got = i - 1;
    end
    check("start_latency", got, lat);
    check("led_at_start", led, 1);
  endtask

  task automatic run_trial(input bit hold_btn, input bit glitch, input int w, input logic [31:0] rt);
    int s0, p0, v0;
    s0 = n_start; p0 = n_stop; v0 = n_rv;
    arm_to_prompt(hold_btn, glitch);
    if (glitch) begin arm = 1'b1; tick(); arm = 1'b0; end
    repeat (w) tick();
    if (hold_btn) begin
      check("held_btn_no_stop", n_stop - p0, 0);
      check("led_while_held", led, 1);
      btn = 1'b0;
      tick();
    end
    btn = 1'b1; tick(); btn = 1'b0;
    check("stop_pulse", stop, 1);
    check("led_off_after_stop", led, 0);
    if (glitch) begin arm = 1'b1; tick(); arm = 1'b0; end
    repeat (w % 3) tick();
    rxn_done = 1'b1; tick(); rxn_done = 1'b0;
    rxn_time = rt; tick();
    rxn_time = $urandom;
    check("result_valid", result_valid, 1);
    check("result", result, rt);
    check("idle_after_capture", busy, 0);
    tick();
    check("result_valid_one_cycle", result_valid, 0);
    check("result_hold", result, rt);
    check("start_count", n_start - s0, 1);
    check("stop_count", n_stop - p0, 1);
    check("valid_count", n_rv - v0, 1);
  endtask

`ifdef RXN_FALSE_START_EN
  task automatic fault_trial(input bit at_zero);
    logic [15:0] lf;
    int s0, at;
    lf = lfsr_nth(cyc);
    at = at_zero ? (MIN_D + int'(lf[RB-1:0]) + 1) : 2;
    s0 = n_start;
    arm = 1'b1;
    for (int i = 1; i <= at; i++) begin tick(); arm = 1'b0; end
    btn = 1'b1; tick(); btn = 1'b0;
    check("false_start_set", false_start, 1);
    check("fault_busy", busy, 1);
    check("fault_led", led, 0);
    repeat (16) tick();
    check("fault_no_start", n_start - s0, 0);
    check("false_start_sticky", false_start, 1);
    run_trial(1'b0, 1'b0, 3, $urandom);
    check("false_start_cleared", false_start, 0);
  endtask
`endif

  initial begin
    logic [15:0] lf;
    int s0, p0, v0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_stop", stop, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_false_start", false_start, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    cyc   = 0;

    lf = lfsr_nth(cyc);
    for (int i = 0; i < 64 && lf[2:0] != 3'd5; i++) begin
      tick();
      lf = lfsr_nth(cyc);
    end
    run_trial(1'b0, 1'b0, 7, 32'd7);

`ifdef RXN_FALSE_START_EN
    fault_trial(1'b0);
    fault_trial(1'b1);
`else
    run_trial(1'b1, 1'b0, 2, $urandom);
    run_trial(1'b1, 1'b1, 4, $urandom);
`endif

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 7)) tick();
      run_trial(1'b0, (k % 2 == 0), $urandom_range(1, 8), $urandom);
    end

    arm_to_prompt(1'b0, 1'b0);
    s0 = n_start; p0 = n_stop; v0 = n_rv;
    #2 rst_n = 1'b0;
    #1;
    check("abort_led", led, 0);
    check("abort_busy", busy, 0);
    check("abort_start", start, 0);
    check("abort_stop", stop, 0);
    check("abort_result", result, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_false_start", false_start, 0);
    btn = 1'b1; tick(); btn = 1'b0;
    rxn_done = 1'b1; tick(); rxn_done = 1'b0;
    rst_n = 1'b1;
    cyc   = 0;
    repeat (6) tick();
    check("abort_no_pulses", (n_start - s0) + (n_stop - p0) + (n_rv - v0), 0);
    check("abort_idle", busy, 0);
    check("abort_result_kept_clear", result, 0);

    check("start_stop_overlap", n_overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
